// File: rtl/facelet_pkg.sv
// Shared types and width helpers for the facelet colour sampler.
// Accumulator and sample-count widths follow from window size and frame count.
package facelet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_ARM    = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_FINISH = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    function automatic int avg_shift(input int log2_side, input int frames_log2);
        return 2 * log2_side + frames_log2;
    endfunction

    function automatic int acc_width(input int pix_w, input int log2_side, input int frames_log2);
        return pix_w + avg_shift(log2_side, frames_log2);
    endfunction

    function automatic int cnt_width(input int log2_side, input int frames_log2);
        return avg_shift(log2_side, frames_log2) + 1;
    endfunction

endpackage

// File: rtl/facelet_cell_acc.sv
// One sample window: coordinate match, pixel sum and sample count, plus the
// final average; the average is forced to zero unless the window was fully sampled.
module facelet_cell_acc
    import facelet_pkg::*;
#(
    parameter int PIX_W       = 10,
    parameter int COORD_W     = 11,
    parameter int LOG2_SIDE   = 1,
    parameter int FRAMES_LOG2 = 0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] anchor_x_i,
    input  logic [COORD_W-1:0] anchor_y_i,
    input  logic [PIX_W-1:0]   pix_i,
    output logic [PIX_W-1:0]   color_o,
    output logic               valid_o
);

    localparam int SHIFT = avg_shift(LOG2_SIDE, FRAMES_LOG2);
    localparam int ACC_W = acc_width(PIX_W, LOG2_SIDE, FRAMES_LOG2);
    localparam int CNT_W = cnt_width(LOG2_SIDE, FRAMES_LOG2);
    localparam logic [COORD_W:0] SIDE_M1  = (COORD_W+1)'((1 << LOG2_SIDE) - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1) << SHIFT;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W:0]   x_ext, y_ext, ax_ext, ay_ext;
    logic               in_win;

    // One extra bit so a window near the top coordinate cannot wrap to zero.
    assign x_ext  = {1'b0, x_i};
    assign y_ext  = {1'b0, y_i};
    assign ax_ext = {1'b0, anchor_x_i};
    assign ay_ext = {1'b0, anchor_y_i};

    assign in_win = (x_ext >= ax_ext) && (x_ext <= ax_ext + SIDE_M1) &&
                    (y_ext >= ay_ext) && (y_ext <= ay_ext + SIDE_M1);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (sample_i && in_win && (cnt_q != CNT_MAX)) begin
            acc_d = acc_q + ACC_W'(pix_i);
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid_o = (cnt_q == CNT_FULL);
    assign color_o = valid_o ? acc_q[ACC_W-1 -: PIX_W] : '0;

endmodule

// File: rtl/facelet_color_sampler.sv
// Start-triggered, frame-synchronous sampler averaging NUM_CELLS square windows
// over 2**FRAMES_LOG2 whole frames; results held until the next capture.
//
//   state  | meaning
//   IDLE   | no capture since reset, waiting for Start
//   SYNC   | capture requested, waiting for the current frame to end
//   ARM    | between frames, waiting for Fval to rise
//   ACCUM  | frame in progress, windows accumulating
//   FINISH | one cycle, latch averages and valid flags
//   DONE   | results valid, waiting for Start
module facelet_color_sampler
    import facelet_pkg::*;
#(
    parameter int NUM_CELLS   = 9,
    parameter int PIX_W       = 10,
    parameter int COORD_W     = 11,
    parameter int LOG2_SIDE   = 1,
    parameter int FRAMES_LOG2 = 0
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Fval,
    input  logic                         Lval,
    input  logic [COORD_W-1:0]           X_Cont,
    input  logic [COORD_W-1:0]           Y_Cont,
    input  logic [PIX_W-1:0]             pixelValue,
    input  logic [NUM_CELLS*COORD_W-1:0] BlockX,
    input  logic [NUM_CELLS*COORD_W-1:0] BlockY,
    output logic [NUM_CELLS*PIX_W-1:0]   Color,
    output logic [NUM_CELLS-1:0]         CellValid,
    output logic                         Busy,
    output logic                         ColorsStored
);

    localparam int FC_W = FRAMES_LOG2 + 1;
    localparam logic [FC_W-1:0] FRAME_LAST = FC_W'((1 << FRAMES_LOG2) - 1);

    state_e                       state_q;
    logic [FC_W-1:0]              frame_q;
    logic [NUM_CELLS*COORD_W-1:0] bx_q, by_q;
    logic [NUM_CELLS*PIX_W-1:0]   color_q;
    logic [NUM_CELLS-1:0]         cell_valid_q;
    logic                         busy_q, stored_q;

    logic                         start_go, sample;
    logic [NUM_CELLS*PIX_W-1:0]   color_all;
    logic [NUM_CELLS-1:0]         valid_all;

    assign start_go = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign sample   = (state_q == ST_ACCUM) && Fval && Lval;

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
        facelet_cell_acc #(
            .PIX_W       (PIX_W),
            .COORD_W     (COORD_W),
            .LOG2_SIDE   (LOG2_SIDE),
            .FRAMES_LOG2 (FRAMES_LOG2)
        ) u_cell (
            .Clk        (Clk),
            .Reset      (Reset),
            .clear_i    (start_go),
            .sample_i   (sample),
            .x_i        (X_Cont),
            .y_i        (Y_Cont),
            .anchor_x_i (bx_q[i*COORD_W +: COORD_W]),
            .anchor_y_i (by_q[i*COORD_W +: COORD_W]),
            .pix_i      (pixelValue),
            .color_o    (color_all[i*PIX_W +: PIX_W]),
            .valid_o    (valid_all[i])
        );
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            color_q      <= '0;
            cell_valid_q <= '0;
            busy_q       <= 1'b0;
            stored_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        bx_q     <= BlockX;
                        by_q     <= BlockY;
                        frame_q  <= '0;
                        busy_q   <= 1'b1;
                        stored_q <= 1'b0;
                        state_q  <= ST_SYNC;
                    end
                end
                ST_SYNC: if (!Fval) state_q <= ST_ARM;
                ST_ARM:  if (Fval)  state_q <= ST_ACCUM;
                ST_ACCUM: begin
                    if (!Fval) begin
                        if (frame_q == FRAME_LAST) begin
                            state_q <= ST_FINISH;
                        end else begin
                            frame_q <= frame_q + FC_W'(1);
                            state_q <= ST_ARM;
                        end
                    end
                end
                ST_FINISH: begin
                    color_q      <= color_all;
                    cell_valid_q <= valid_all;
                    busy_q       <= 1'b0;
                    stored_q     <= 1'b1;
                    state_q      <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Color        = color_q;
    assign CellValid    = cell_valid_q;
    assign Busy         = busy_q;
    assign ColorsStored = stored_q;

endmodule
